rv_iopmp_txn_initiator: RTL and testbench
=========================================

Name: rv_iopmp_txn_initiator

Overview:
- Request-side front end for the IOPMP transaction checker.
- Accepts one bus-side request at a time on a valid/ready channel and registers it.
- Issues the request to the checker through its transaction_en/ready/valid/allow interface and waits for the verdict.
- On allow, forwards the request downstream; on deny, returns an error response upstream. Counts denials.

Parameters:
- ADDR_WIDTH, 64, address and length width in bits
- DATA_WIDTH, 64, bus data width; sets beat-size clamp and num_bytes width
- SID_WIDTH, 8, source-ID width
- TIMEOUT_CYCLES, 255, verdict watchdog limit; used only with the optional feature

Ports:
- clk_i  in  1  rising-edge clock
- rst_ni  in  1  asynchronous reset, active low
- req_valid_i  in  1  upstream request valid
- req_ready_o  out  1  upstream request ready
- req_addr_i  in  ADDR_WIDTH  start address
- req_len_i  in  ADDR_WIDTH  total length in bytes
- req_size_i  in  3  log2 of beat bytes
- req_sid_i  in  SID_WIDTH  source ID
- req_access_i  in  rv_iopmp_pkg::access_t  access type
- chk_en_o  out  1  transaction_en to checker
- chk_ready_i  in  1  checker ready (checker idle)
- chk_addr_o  out  ADDR_WIDTH  registered address
- chk_total_length_o  out  ADDR_WIDTH  registered length
- chk_num_bytes_o  out  $clog2(DATA_WIDTH/8)+1  beat bytes
- chk_sid_o  out  SID_WIDTH  registered SID
- chk_access_o  out  rv_iopmp_pkg::access_t  registered access type
- chk_valid_i  in  1  checker verdict strobe
- chk_allow_i  in  1  checker verdict; qualified by chk_valid_i
- fwd_valid_o  out  1  downstream request valid
- fwd_ready_i  in  1  downstream ready
- fwd_addr_o / fwd_len_o  out  ADDR_WIDTH each  forwarded address and length
- fwd_sid_o  out  SID_WIDTH  forwarded SID
- fwd_access_o  out  rv_iopmp_pkg::access_t  forwarded access type
- err_valid_o  out  1  error response valid
- err_ready_i  in  1  error response ready
- err_sid_o  out  SID_WIDTH  SID of the denied request
- err_timeout_o  out  1  denial caused by watchdog; qualified by err_valid_o
- deny_cnt_o  out  32  saturating denial counter

Behaviour:
- Reset: state IDLE; all registers 0; req_ready_o=1; chk_en_o, fwd_valid_o, err_valid_o, err_timeout_o = 0; deny_cnt_o=0.
- Reset is asynchronous. Reset mid-transaction drops the request silently, with no response.
- chk_*/fwd_*/err_sid_o are driven from one capture register that is loaded only on accept.
- States are IDLE, ISSUE, WAIT, FWD, DENY.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, capture the request.
  - If req_len_i==0: go to DENY, no checker transaction issued.
  - Otherwise: go to ISSUE.
- ISSUE:
  - chk_en_o = chk_ready_i.
  - When chk_ready_i=1, go to WAIT next cycle; chk_en_o is high for exactly one cycle.
  - Otherwise hold.
- WAIT:
  - On chk_valid_i: chk_allow_i=1 goes to FWD; chk_allow_i=0 goes to DENY.
  - chk_valid_i is ignored in every other state.
  - Minimum WAIT-to-verdict is 1 cycle, so minimum accept-to-fwd_valid_o is 3 cycles.
- FWD: fwd_valid_o=1 and held stable until fwd_ready_i; then go to IDLE.
- DENY:
  - err_valid_o=1 and held stable until err_ready_i; then go to IDLE.
  - deny_cnt_o increments once, on DENY entry, saturating at 0xFFFF_FFFF.
- No back-to-back accept: req_ready_o=0 in every state except IDLE.
- chk_num_bytes_o = 1 << min(req_size_i, $clog2(DATA_WIDTH/8)); out-of-range sizes are clamped.
- chk_total_length_o carries req_len_i unchanged; the checker computes the final address.

Optional Feature:
- Macro: IOPMP_CHECK_TIMEOUT_EN.
- Defined:
  - A counter clears on WAIT entry and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without chk_valid_i, go to DENY with err_timeout_o=1.
  - A verdict arriving in the same cycle as expiry wins over the timeout.
  - A late verdict is ignored.
  - err_timeout_o clears on leaving DENY.
- Not defined: WAIT is unbounded and err_timeout_o is tied 0.

Test Plan:
- Req addr=0x8000_0000, len=64, size=3, sid=1; chk_ready_i=1; checker returns valid+allow 1 cycle after chk_en_o -> one-cycle chk_en_o; fwd_valid_o with addr 0x8000_0000, len 64; chk_num_bytes_o=8; deny_cnt_o stays 0.
- Same request, checker returns allow=0 -> err_valid_o with err_sid_o=1; deny_cnt_o=1; no fwd_valid_o.
- chk_ready_i low for 5 cycles in ISSUE -> chk_en_o stays 0 until ready, then pulses once.
- req_len_i=0 -> chk_en_o never asserted; err_valid_o; deny_cnt_o increments; req_size_i=7 with DATA_WIDTH=64 -> chk_num_bytes_o=8.
- fwd_ready_i held low 10 cycles -> fwd_valid_o and payload stable; req_ready_o=0 throughout; rst_ni pulsed mid-FWD -> all outputs return to reset values.
- With IOPMP_CHECK_TIMEOUT_EN, TIMEOUT_CYCLES=4, no verdict -> err_valid_o and err_timeout_o after 4 WAIT cycles; a chk_valid_i arriving later is ignored.

Source files
------------

// File: rtl/rv_iopmp_txn_initiator.sv
// ---------------------------------------------------------------------------
// rv_iopmp_pkg / rv_iopmp_txn_initiator
//
// Purpose: request-side front end for the IOPMP transaction checker. Takes one
// upstream request at a time, registers it, runs it through the checker's
// transaction_en/ready/valid/allow handshake, then either forwards it
// downstream (allow) or returns an error response upstream (deny). Denials are
// counted in a saturating 32-bit counter.
//
// Optional feature (compile-time macro IOPMP_CHECK_TIMEOUT_EN): a verdict
// watchdog that denies the request with err_timeout_o=1 after TIMEOUT_CYCLES
// cycles in WAIT without a verdict. Without the macro WAIT is unbounded and
// err_timeout_o is tied low.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_*                      upstream request channel (valid/ready + payload)
//   chk_en_o / chk_ready_i     transaction_en to checker / checker idle
//   chk_addr_o ... chk_access_o registered request presented to the checker
//   chk_valid_i / chk_allow_i  checker verdict strobe and verdict
//   fwd_*                      downstream request channel (valid/ready + payload)
//   err_valid_o / err_ready_i  error response channel
//   err_sid_o, err_timeout_o   SID of denied request, watchdog-denial flag
//   deny_cnt_o                 saturating denial counter
// ---------------------------------------------------------------------------

package rv_iopmp_pkg;
    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'd0,
        ACCESS_READ  = 2'd1,
        ACCESS_WRITE = 2'd2,
        ACCESS_EXEC  = 2'd3
    } access_t;
endpackage

module rv_iopmp_txn_initiator #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int SID_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,

    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic [ADDR_WIDTH-1:0]                req_addr_i,
    input  logic [ADDR_WIDTH-1:0]                req_len_i,
    input  logic [2:0]                           req_size_i,
    input  logic [SID_WIDTH-1:0]                 req_sid_i,
    input  rv_iopmp_pkg::access_t                req_access_i,

    output logic                                 chk_en_o,
    input  logic                                 chk_ready_i,
    output logic [ADDR_WIDTH-1:0]                chk_addr_o,
    output logic [ADDR_WIDTH-1:0]                chk_total_length_o,
    output logic [$clog2(DATA_WIDTH/8):0]        chk_num_bytes_o,
    output logic [SID_WIDTH-1:0]                 chk_sid_o,
    output rv_iopmp_pkg::access_t                chk_access_o,
    input  logic                                 chk_valid_i,
    input  logic                                 chk_allow_i,

    output logic                                 fwd_valid_o,
    input  logic                                 fwd_ready_i,
    output logic [ADDR_WIDTH-1:0]                fwd_addr_o,
    output logic [ADDR_WIDTH-1:0]                fwd_len_o,
    output logic [SID_WIDTH-1:0]                 fwd_sid_o,
    output rv_iopmp_pkg::access_t                fwd_access_o,

    output logic                                 err_valid_o,
    input  logic                                 err_ready_i,
    output logic [SID_WIDTH-1:0]                 err_sid_o,
    output logic                                 err_timeout_o,

    output logic [31:0]                          deny_cnt_o
);

    localparam int MAX_LOG = $clog2(DATA_WIDTH / 8);
    localparam int NB_W    = MAX_LOG + 1;

    // Elaboration-time sanity checks on the configuration.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end
    if (DATA_WIDTH < 8) begin : g_bad_data_width
        $error("DATA_WIDTH must be at least 8");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        FWD   = 3'd3,
        DENY  = 3'd4
    } state_e;

    // Beat size in bytes; sizes wider than the bus are clamped to the bus width.
    function automatic logic [NB_W-1:0] beat_bytes(input logic [2:0] size);
        logic [2:0] eff;
        if (int'(size) > MAX_LOG) eff = 3'(MAX_LOG);
        else                      eff = size;
        return NB_W'(1) << eff;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    state_e                 state_q;
    logic                   req_ready_q;
    logic                   fwd_valid_q;
    logic                   err_valid_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH-1:0]  len_q;
    logic [NB_W-1:0]        nbytes_q;
    logic [SID_WIDTH-1:0]   sid_q;
    rv_iopmp_pkg::access_t  access_q;
    logic [31:0]            deny_cnt_q;
    logic [31:0]            deny_cnt_d;

`ifdef IOPMP_CHECK_TIMEOUT_EN
    localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0]             tmo_cnt_q;
    logic                         err_timeout_q;
`endif

    assign deny_cnt_d = sat_inc(deny_cnt_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            // The only flag that is 1 out of reset: IDLE accepts immediately.
            req_ready_q   <= 1'b1;
            fwd_valid_q   <= 1'b0;
            err_valid_q   <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            nbytes_q      <= '0;
            sid_q         <= '0;
            access_q      <= rv_iopmp_pkg::ACCESS_NONE;
            deny_cnt_q    <= '0;
`ifdef IOPMP_CHECK_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q      <= req_addr_i;
                        len_q       <= req_len_i;
                        nbytes_q    <= beat_bytes(req_size_i);
                        sid_q       <= req_sid_i;
                        access_q    <= req_access_i;
                        req_ready_q <= 1'b0;
                        // Zero-length requests are refused locally; the checker
                        // never sees them.
                        if (req_len_i == '0) begin
                            state_q     <= DENY;
                            err_valid_q <= 1'b1;
                            deny_cnt_q  <= deny_cnt_d;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    // chk_en_o fires combinationally in this cycle; leaving
                    // ISSUE right away keeps it a single-cycle pulse.
                    if (chk_ready_i) begin
                        state_q <= WAIT;
`ifdef IOPMP_CHECK_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end

                WAIT: begin
                    // A verdict in the expiry cycle takes priority over the
                    // watchdog.
                    if (chk_valid_i) begin
                        if (chk_allow_i) begin
                            state_q     <= FWD;
                            fwd_valid_q <= 1'b1;
                        end else begin
                            state_q     <= DENY;
                            err_valid_q <= 1'b1;
                            deny_cnt_q  <= deny_cnt_d;
                        end
                    end
`ifdef IOPMP_CHECK_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LAST) begin
                        state_q       <= DENY;
                        err_valid_q   <= 1'b1;
                        err_timeout_q <= 1'b1;
                        deny_cnt_q    <= deny_cnt_d;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end

                FWD: begin
                    if (fwd_ready_i) begin
                        state_q     <= IDLE;
                        fwd_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end

                DENY: begin
                    if (err_ready_i) begin
                        state_q     <= IDLE;
                        err_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
`ifdef IOPMP_CHECK_TIMEOUT_EN
                        err_timeout_q <= 1'b0;
`endif
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    fwd_valid_q <= 1'b0;
                    err_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
`ifdef IOPMP_CHECK_TIMEOUT_EN
                    err_timeout_q <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign req_ready_o        = req_ready_q;
    assign chk_en_o           = (state_q == ISSUE) && chk_ready_i;
    assign chk_addr_o         = addr_q;
    assign chk_total_length_o = len_q;
    assign chk_num_bytes_o    = nbytes_q;
    assign chk_sid_o          = sid_q;
    assign chk_access_o       = access_q;

    assign fwd_valid_o        = fwd_valid_q;
    assign fwd_addr_o         = addr_q;
    assign fwd_len_o          = len_q;
    assign fwd_sid_o          = sid_q;
    assign fwd_access_o       = access_q;

    assign err_valid_o        = err_valid_q;
    assign err_sid_o          = sid_q;
`ifdef IOPMP_CHECK_TIMEOUT_EN
    assign err_timeout_o      = err_timeout_q;
`else
    assign err_timeout_o      = 1'b0;
`endif

    assign deny_cnt_o         = deny_cnt_q;

endmodule

// File: tb/tb_rv_iopmp_txn_initiator.sv
// Bench for rv_iopmp_txn_initiator: directed cases plus randomized
// transactions, each checked against an outcome/latency model derived from the
// request and the behaviour chosen for the checker and downstream agents.
module tb_rv_iopmp_txn_initiator;
    import rv_iopmp_pkg::*;

    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int SW  = 8;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          req_valid_i, req_ready_o;
    logic [AW-1:0] req_addr_i, req_len_i;
    logic [2:0]    req_size_i;
    logic [SW-1:0] req_sid_i;
    access_t       req_access_i;
    logic          chk_en_o, chk_ready_i;
    logic [AW-1:0] chk_addr_o, chk_total_length_o;
    logic [3:0]    chk_num_bytes_o;
    logic [SW-1:0] chk_sid_o;
    access_t       chk_access_o;
    logic          chk_valid_i, chk_allow_i;
    logic          fwd_valid_o, fwd_ready_i;
    logic [AW-1:0] fwd_addr_o, fwd_len_o;
    logic [SW-1:0] fwd_sid_o;
    access_t       fwd_access_o;
    logic          err_valid_o, err_ready_i;
    logic [SW-1:0] err_sid_o;
    logic          err_timeout_o;
    logic [31:0]   deny_cnt_o;

    always #5 clk = ~clk;

    rv_iopmp_txn_initiator #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SID_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_size_i(req_size_i),
        .req_sid_i(req_sid_i), .req_access_i(req_access_i),
        .chk_en_o(chk_en_o), .chk_ready_i(chk_ready_i),
        .chk_addr_o(chk_addr_o), .chk_total_length_o(chk_total_length_o),
        .chk_num_bytes_o(chk_num_bytes_o), .chk_sid_o(chk_sid_o),
        .chk_access_o(chk_access_o),
        .chk_valid_i(chk_valid_i), .chk_allow_i(chk_allow_i),
        .fwd_valid_o(fwd_valid_o), .fwd_ready_i(fwd_ready_i),
        .fwd_addr_o(fwd_addr_o), .fwd_len_o(fwd_len_o), .fwd_sid_o(fwd_sid_o),
        .fwd_access_o(fwd_access_o),
        .err_valid_o(err_valid_o), .err_ready_i(err_ready_i),
        .err_sid_o(err_sid_o), .err_timeout_o(err_timeout_o),
        .deny_cnt_o(deny_cnt_o)
    );

    int          total = 0;
    int          bad   = 0;
    int unsigned m_deny = 0;   // model of the denial counter

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_req_ready"}, req_ready_o, 1);
        check_eq({pfx, "_chk_en"}, chk_en_o, 0);
        check_eq({pfx, "_fwd_valid"}, fwd_valid_o, 0);
        check_eq({pfx, "_err_valid"}, err_valid_o, 0);
        check_eq({pfx, "_err_tmo"}, err_timeout_o, 0);
        check_eq({pfx, "_deny_cnt"}, deny_cnt_o, 0);
        check_eq({pfx, "_addr"}, chk_addr_o, 0);
        check_eq({pfx, "_nbytes"}, chk_num_bytes_o, 0);
        check_eq({pfx, "_sid"}, fwd_sid_o, 0);
    endtask

    // One complete transaction. vdly: cycles after chk_en before the verdict
    // (negative = never). out_dly: cycles the response is held before the
    // downstream/upstream ready. rst_at > 0 pulses reset at that cycle.
    task automatic run_txn(input logic [63:0] addr, input logic [63:0] len,
                           input logic [2:0] size, input logic [7:0] sid,
                           input access_t acc, input int rdy_dly, input int vdly,
                           input bit allow, input int out_dly, input int rst_at);
        int   exp_en_cnt, exp_en_cyc, exp_resp, exp_nb;
        bit   exp_err, exp_tmo;
        int   en_cnt, en_cyc, resp_cyc, ready_hi, unstable;
        bit   done, got_err, got_fwd, got_tmo;
        logic [63:0] c_addr, c_len, f_addr, f_len, r_deny;
        logic [7:0]  c_sid, f_sid, e_sid;
        logic [3:0]  c_nb;
        access_t     c_acc, f_acc;

        // Reference expectations.
        exp_nb = 1 << ((size > 3) ? 3 : int'(size));
        exp_tmo = 1'b0;
        if (len == 0) begin
            exp_en_cnt = 0; exp_en_cyc = -1; exp_resp = 1; exp_err = 1'b1;
        end else begin
            exp_en_cnt = 1; exp_en_cyc = 1 + rdy_dly;
`ifdef IOPMP_CHECK_TIMEOUT_EN
            if (vdly < 0 || vdly >= TMO) begin
                exp_resp = exp_en_cyc + 1 + TMO; exp_err = 1'b1; exp_tmo = 1'b1;
            end else
`endif
            begin
                exp_resp = exp_en_cyc + 2 + vdly; exp_err = !allow;
            end
        end

        en_cnt = 0; en_cyc = -1; resp_cyc = -1; ready_hi = 0; unstable = 0;
        done = 0; got_err = 0; got_fwd = 0; got_tmo = 0;
        c_addr = 0; c_len = 0; c_sid = 0; c_nb = 0; c_acc = ACCESS_NONE;
        f_addr = 0; f_len = 0; f_sid = 0; f_acc = ACCESS_NONE; e_sid = 0; r_deny = 0;

        // Cycle 0: present the request.
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_addr_i = addr; req_len_i = len; req_size_i = size;
        req_sid_i = sid; req_access_i = acc;
        chk_ready_i = 1'b0; chk_valid_i = 1'b0; chk_allow_i = 1'b0;
        fwd_ready_i = 1'b0; err_ready_i = 1'b0;
        #1;
        check_eq("req_ready_idle", req_ready_o, 1);
        check_eq("tmo_idle", err_timeout_o, 0);

        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                // Scramble the request bus: captured values must not follow it.
                req_valid_i = 1'b0;
                req_addr_i = {$urandom, $urandom}; req_len_i = {$urandom, $urandom};
                req_sid_i = 8'($urandom); req_size_i = 3'($urandom);
            end
            if (rst_at > 0 && c == rst_at) begin
                chk_ready_i = 1'b1;
                rst_ni = 1'b0;
                #1;
                check_reset_outputs("rst_mid");
                @(posedge clk); #1;
                rst_ni = 1'b1;
                m_deny = 0;
                fwd_ready_i = 1'b0; err_ready_i = 1'b0; chk_valid_i = 1'b0;
                @(posedge clk); #1;
                check_eq("rst_after_fwd_valid", fwd_valid_o, 0);
                check_eq("rst_after_err_valid", err_valid_o, 0);
                check_eq("rst_after_req_ready", req_ready_o, 1);
                return;
            end
            // Checker agent.
            if (en_cyc < 0 && exp_en_cyc > 0) chk_ready_i = (c >= exp_en_cyc);
            else                              chk_ready_i = 1'($urandom_range(0, 1));
            if (vdly >= 0 && en_cyc >= 0 && c == en_cyc + 1 + vdly) begin
                chk_valid_i = 1'b1; chk_allow_i = allow;
            end else if (en_cyc >= 0 && resp_cyc < 0) begin
                chk_valid_i = 1'b0; chk_allow_i = 1'($urandom_range(0, 1));
            end else begin
                chk_valid_i = 1'($urandom_range(0, 1)); chk_allow_i = 1'($urandom_range(0, 1));
            end
            // Response-side agents.
            fwd_ready_i = (c >= exp_resp + out_dly);
            err_ready_i = (c >= exp_resp + out_dly);
            #1;
            if (chk_en_o) begin
                en_cnt++;
                if (en_cyc < 0) begin
                    en_cyc = c; c_addr = chk_addr_o; c_len = chk_total_length_o;
                    c_sid = chk_sid_o; c_nb = chk_num_bytes_o; c_acc = chk_access_o;
                end
            end
            if (req_ready_o) ready_hi++;
            if (fwd_valid_o || err_valid_o) begin
                if (resp_cyc < 0) begin
                    resp_cyc = c; got_fwd = fwd_valid_o; got_err = err_valid_o;
                    got_tmo = err_timeout_o; f_addr = fwd_addr_o; f_len = fwd_len_o;
                    f_sid = fwd_sid_o; f_acc = fwd_access_o; e_sid = err_sid_o;
                    r_deny = deny_cnt_o;
                end else if (fwd_valid_o !== got_fwd || err_valid_o !== got_err ||
                             err_timeout_o !== got_tmo || fwd_addr_o !== f_addr ||
                             fwd_len_o !== f_len || fwd_sid_o !== f_sid ||
                             fwd_access_o !== f_acc || err_sid_o !== e_sid) begin
                    unstable++;
                end
            end
            if ((fwd_valid_o && fwd_ready_i) || (err_valid_o && err_ready_i)) begin
                done = 1;
                break;
            end
        end

        if (exp_err) m_deny++;
        check_eq("txn_done", done, 1);
        check_eq("chk_en_count", en_cnt, exp_en_cnt);
        if (exp_en_cnt == 1) begin
            check_eq("chk_en_cycle", en_cyc, exp_en_cyc);
            check_eq("chk_addr", c_addr, addr);
            check_eq("chk_len", c_len, len);
            check_eq("chk_sid", c_sid, sid);
            check_eq("chk_acc", c_acc, acc);
            check_eq("chk_nbytes", c_nb, exp_nb);
        end
        check_eq("resp_cycle", resp_cyc, exp_resp);
        check_eq("resp_fwd", got_fwd, !exp_err);
        check_eq("resp_err", got_err, exp_err);
        check_eq("resp_tmo", got_tmo, exp_tmo);
        check_eq("resp_stable", unstable, 0);
        check_eq("req_ready_busy", ready_hi, 0);
        check_eq("deny_cnt", r_deny, m_deny);
        if (exp_err) check_eq("err_sid", e_sid, sid);
        else begin
            check_eq("fwd_addr", f_addr, addr);
            check_eq("fwd_len", f_len, len);
            check_eq("fwd_sid", f_sid, sid);
            check_eq("fwd_acc", f_acc, acc);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        req_valid_i = 0; req_addr_i = 0; req_len_i = 0; req_size_i = 0; req_sid_i = 0;
        req_access_i = ACCESS_NONE; chk_ready_i = 1'b1; chk_valid_i = 0; chk_allow_i = 0;
        fwd_ready_i = 0; err_ready_i = 0;
        #12;
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst_ni = 1'b1;

        // Basic allow, then the same request denied.
        run_txn(64'h8000_0000, 64, 3'd3, 8'd1, ACCESS_READ, 0, 0, 1'b1, 0, 0);
        run_txn(64'h8000_0000, 64, 3'd3, 8'd1, ACCESS_READ, 0, 0, 1'b0, 0, 0);
        // Checker busy for 5 cycles in ISSUE.
        run_txn(64'h1234_5678_9abc_def0, 128, 3'd2, 8'd7, ACCESS_WRITE, 5, 1, 1'b1, 0, 0);
        // Zero length: local denial, no checker traffic; oversize beat clamps.
        run_txn(64'h4000, 0, 3'd7, 8'd9, ACCESS_EXEC, 0, 0, 1'b1, 2, 0);
        run_txn(64'h4000, 32, 3'd7, 8'd10, ACCESS_READ, 1, 2, 1'b1, 10, 0);
        // Downstream stalled 10 cycles.
        run_txn(64'hdead_beef_0000, 4096, 3'd0, 8'd33, ACCESS_WRITE, 0, 0, 1'b1, 10, 0);
`ifdef IOPMP_CHECK_TIMEOUT_EN
        // Watchdog: no verdict; verdict in the expiry cycle; late verdict.
        run_txn(64'h100, 16, 3'd1, 8'd44, ACCESS_READ, 0, -1, 1'b1, 3, 0);
        run_txn(64'h200, 16, 3'd1, 8'd45, ACCESS_READ, 0, TMO - 1, 1'b1, 0, 0);
        run_txn(64'h300, 16, 3'd1, 8'd46, ACCESS_READ, 2, TMO + 1, 1'b1, 5, 0);
`endif
        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            logic [63:0] a, l;
            int vmax;
`ifdef IOPMP_CHECK_TIMEOUT_EN
            vmax = TMO + 2;
`else
            vmax = 9;
`endif
            a = {$urandom, $urandom};
            l = ($urandom_range(0, 7) == 0) ? 64'd0 : 64'($urandom_range(1, 65535));
            run_txn(a, l, 3'($urandom_range(0, 7)), 8'($urandom),
                    access_t'($urandom_range(0, 3)), $urandom_range(0, 4),
                    $urandom_range(0, vmax), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 0);
        end
        // Reset pulsed while a forward is stalled (response appears at cycle 3).
        run_txn(64'h8000_0000, 64, 3'd3, 8'd1, ACCESS_READ, 0, 0, 1'b1, 50, 6);
        // Clean transaction after the reset.
        run_txn(64'h9000_0000, 8, 3'd3, 8'd2, ACCESS_WRITE, 0, 0, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
